fp_normalize_left: RTL and testbench
====================================

// Module: fp_normalize_left
// PURPOSE
//  Post-add normalizer for the FP32 adder datapath; the inverse of the alignment right-shifter.
//  Takes a raw 25-bit sum mantissa (carry + 24 bits, hidden bit at [23]) and its exponent.
//  Normalizes iteratively, one left shift per cycle, or one right shift on carry-out.
//  Emits a 24-bit normalized mantissa plus exponent and status flags over valid/ready handshakes.
// PARAMETERS
//  MW  24  mantissa width incl. hidden bit (input is MW+1 bits)
//  EW  8   exponent width
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     synchronous, active-high reset
//  in_valid   in   1     mant_in/exp_in valid
//  in_ready   out  1     block can accept (high only in IDLE)
//  mant_in    in   MW+1  raw sum mantissa, [MW]=carry
//  exp_in     in   EW    biased exponent of sum
//  out_valid  out  1     result valid (high only in DONE)
//  out_ready  in   1     consumer accepts result
//  mant_out   out  MW    normalized mantissa, [MW-1]=hidden bit
//  exp_out    out  EW    biased exponent result
//  zero       out  1     result is exact zero
//  overflow   out  1     exponent saturated to all-ones (inf), mant_out=0
//  underflow  out  1     result denormal, exp_out=0
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high on `reset`.
//  - Reset (any state, incl. mid-shift): state=IDLE; all outputs 0 except in_ready=1; work discarded.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE: in_ready=1. On in_valid, capture the inputs; next state per the first matching rule:
//    - mant_in==0 -> DONE: mant 0, exp 0, zero=1.
//    - mant_in[MW]==1 -> mant=mant_in>>1 (LSB truncated), exp=exp_in+1 -> DONE.
//      If exp_in==2^EW-2: exp=all-ones, mant=0, overflow=1.
//    - mant_in[MW-1]==1 -> DONE unchanged.
//    - exp_in<=1 -> DONE: exp 0, mant unchanged, underflow=1.
//    - otherwise -> SHIFT.
//  - SHIFT: in_ready=0, out_valid=0. Each cycle:
//    - exp_reg==1 -> DONE: exp 0, underflow=1, no shift.
//    - else mant<<=1, exp-=1; if the shifted mant[MW-1]==1 -> DONE, else stay in SHIFT.
//  - DONE: out_valid=1; outputs and flags held stable while out_ready=0.
//    - out_valid&&out_ready -> IDLE; out_valid drops the next cycle.
//  - No same-cycle accept in DONE; one item in flight max.
//  - Latency: accept at edge N -> out_valid at N+1+k, where k = leading zeros below the hidden bit
//    (k=0 when no shift is needed); worst case k=MW-1.
//  - Flags mutually exclusive; all cleared on leaving DONE.
//  - Exponent arithmetic is unsigned EW-bit and never wraps; the underflow and overflow rules guard both ends.
// TESTING
//  1. mant_in=25'h0800000 exp_in=8'h80 -> out_valid 1 cycle after accept; mant_out 24'h800000, exp 8'h80, flags 0.
//  2. mant_in=25'h0000001 exp_in=8'h80 -> out_valid 24 cycles after accept; mant_out 24'h800000, exp 8'h69.
//  3. mant_in=25'h1800000 exp_in=8'h80 -> mant_out 24'hC00000, exp 8'h81; mant_in=25'h1000000 exp_in=8'hFE -> exp 8'hFF, mant 0, overflow=1.
//  4. mant_in=0 exp_in=8'h55 -> zero=1, exp 0, mant 0, 1 cycle.
//  5. mant_in=25'h0000100 exp_in=8'h03 -> 3 cycles: mant_out 24'h000400, exp 0, underflow=1.
//  6. Case 2 with out_ready=0 for 5 cycles -> outputs stable, in_ready=0; reset asserted mid-SHIFT -> IDLE next cycle, out_valid never rises.

Source files
------------

// File: rtl/fp_normalize_left_if.sv
// Handshake bundle between the FP32 adder sum stage and the post-add normalizer.
// The normalizer is the slave; the producer/consumer environment is the master.
interface fp_normalize_left_if #(
  parameter int MW = 24,
  parameter int EW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [MW:0]   mant_in;
  logic [EW-1:0] exp_in;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] mant_out;
  logic [EW-1:0] exp_out;
  logic          zero;
  logic          overflow;
  logic          underflow;

  modport master (
    output in_valid, mant_in, exp_in, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, zero, overflow, underflow
  );

  modport slave (
    input  in_valid, mant_in, exp_in, out_ready,
    output in_ready, out_valid, mant_out, exp_out, zero, overflow, underflow
  );
endinterface

// File: rtl/fp_normalize_left.sv
// Post-add normalizer for the FP32 adder: one left shift per cycle until the hidden bit is set,
// or a single right shift when the sum carried out, with exponent saturation at both ends.
module fp_normalize_left #(
  parameter int MW = 24,
  parameter int EW = 8
) (
  input  logic                clk,
  input  logic                reset,
  fp_normalize_left_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic [EW-1:0] EXP_MAX  = '1;
  localparam logic [EW-1:0] EXP_SAT  = EXP_MAX - EXP_ONE;

  state_t        state, state_n;
  logic [MW-1:0] mant_reg, mant_n;
  logic [EW-1:0] exp_reg, exp_n;
  logic          zero_reg, zero_n;
  logic          ovf_reg, ovf_n;
  logic          unf_reg, unf_n;

  // State and datapath registers; reset discards any item in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mant_reg <= '0;
      exp_reg  <= '0;
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
    end else begin
      state    <= state_n;
      mant_reg <= mant_n;
      exp_reg  <= exp_n;
      zero_reg <= zero_n;
      ovf_reg  <= ovf_n;
      unf_reg  <= unf_n;
    end
  end

  // Classification at accept time decides whether any shifting is needed at all;
  // an exponent of all-ones on a carry would wrap, so it saturates like the one below it.
  always_comb begin
    state_n = state;
    mant_n  = mant_reg;
    exp_n   = exp_reg;
    zero_n  = zero_reg;
    ovf_n   = ovf_reg;
    unf_n   = unf_reg;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          zero_n  = 1'b0;
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          mant_n  = bus.mant_in[MW-1:0];
          exp_n   = bus.exp_in;
          state_n = DONE;
          if (bus.mant_in == '0) begin
            mant_n = '0;
            exp_n  = '0;
            zero_n = 1'b1;
          end else if (bus.mant_in[MW]) begin
            if (bus.exp_in >= EXP_SAT) begin
              mant_n = '0;
              exp_n  = EXP_MAX;
              ovf_n  = 1'b1;
            end else begin
              mant_n = bus.mant_in[MW:1];
              exp_n  = bus.exp_in + EXP_ONE;
            end
          end else if (bus.mant_in[MW-1]) begin
            state_n = DONE;
          end else if (bus.exp_in <= EXP_ONE) begin
            exp_n = '0;
            unf_n = 1'b1;
          end else begin
            state_n = SHIFT;
          end
        end
      end

      SHIFT: begin
        // Reaching exponent 1 means one more shift would leave the normal range.
        if (exp_reg == EXP_ONE) begin
          exp_n   = '0;
          unf_n   = 1'b1;
          state_n = DONE;
        end else begin
          mant_n = {mant_reg[MW-2:0], 1'b0};
          exp_n  = exp_reg - EXP_ONE;
          if (mant_reg[MW-2]) begin
            state_n = DONE;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          zero_n  = 1'b0;
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Result fields are only visible while the result is being offered.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.mant_out  = '0;
    bus.exp_out   = '0;
    bus.zero      = 1'b0;
    bus.overflow  = 1'b0;
    bus.underflow = 1'b0;
    if (state == DONE) begin
      bus.mant_out  = mant_reg;
      bus.exp_out   = exp_reg;
      bus.zero      = zero_reg;
      bus.overflow  = ovf_reg;
      bus.underflow = unf_reg;
    end
  end

endmodule

// File: tb/tb_fp_normalize_left.sv
// Directed-vector bench for fp_normalize_left: a table of sums with hand-computed results,
// plus hand-written stall and mid-shift reset sequences.
module tb_fp_normalize_left;

  localparam int MW = 24;
  localparam int EW = 8;
  localparam int NVEC = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_normalize_left_if #(.MW(MW), .EW(EW)) bus ();

  fp_normalize_left #(.MW(MW), .EW(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [24:0] mant;
    logic [7:0]  ex;
    logic [23:0] emant;
    logic [7:0]  eex;
    logic        ez;
    logic        eo;
    logic        eu;
    logic [5:0]  shifts;
  } vec_t;

  vec_t vecs [NVEC];
  int   napplied = 0;
  int   nmiss = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    napplied++;
    if (act !== req) begin
      nmiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Offers one sum, waits for the accept edge, then counts cycles until the result is offered.
  task automatic applyStimulus(input logic [24:0] m, input logic [7:0] e,
                               output int shifts, output bit ok);
    @(negedge clk);
    bus.mant_in  = m;
    bus.exp_in   = e;
    bus.in_valid = 1'b1;
    checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    shifts = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      shifts++;
    end
    if (!ok) begin
      napplied++;
      nmiss++;
      $display("[TB] FAIL timeout: out_valid never rose for mant %h exp %h", m, e);
    end
  endtask

  task automatic checkResult(input int idx, input int shifts);
    vec_t v;
    v = vecs[idx];
    checkOutput($sformatf("v%0d_shifts", idx), 32'(shifts), 32'(v.shifts));
    checkOutput($sformatf("v%0d_mant", idx), 32'(bus.mant_out), 32'(v.emant));
    checkOutput($sformatf("v%0d_exp", idx), 32'(bus.exp_out), 32'(v.eex));
    checkOutput($sformatf("v%0d_flags", idx),
                32'({bus.zero, bus.overflow, bus.underflow}), 32'({v.ez, v.eo, v.eu}));
    checkOutput($sformatf("v%0d_in_ready_busy", idx), 32'(bus.in_ready), 32'd0);
  endtask

  task automatic releaseResult(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput({name, "_ovalid_drop"}, 32'(bus.out_valid), 32'd0);
    checkOutput({name, "_flags_clear"},
                32'({bus.zero, bus.overflow, bus.underflow}), 32'd0);
    checkOutput({name, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic runVector(input int idx);
    int shifts;
    bit ok;
    applyStimulus(vecs[idx].mant, vecs[idx].ex, shifts, ok);
    if (ok) begin
      checkResult(idx, shifts);
      releaseResult($sformatf("v%0d", idx));
    end else begin
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
    end
  endtask

  initial begin
    int  shifts;
    bit  ok;
    bit  seen;
    logic [23:0] held_mant;
    logic [7:0]  held_exp;

    //                mant          exp    emant        eex    z     o     u     shifts
    vecs[0]  = '{25'h0800000, 8'h80, 24'h800000, 8'h80, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[1]  = '{25'h0000001, 8'h80, 24'h800000, 8'h69, 1'b0, 1'b0, 1'b0, 6'd23};
    vecs[2]  = '{25'h1800000, 8'h80, 24'hC00000, 8'h81, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[3]  = '{25'h1000000, 8'hFE, 24'h000000, 8'hFF, 1'b0, 1'b1, 1'b0, 6'd0};
    vecs[4]  = '{25'h0000000, 8'h55, 24'h000000, 8'h00, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[5]  = '{25'h0000100, 8'h03, 24'h000400, 8'h00, 1'b0, 1'b0, 1'b1, 6'd3};
    vecs[6]  = '{25'h0400000, 8'h80, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0, 6'd1};
    vecs[7]  = '{25'h0400000, 8'h01, 24'h400000, 8'h00, 1'b0, 1'b0, 1'b1, 6'd0};
    vecs[8]  = '{25'h0000001, 8'h18, 24'h800000, 8'h01, 1'b0, 1'b0, 1'b0, 6'd23};
    vecs[9]  = '{25'h0000001, 8'h17, 24'h400000, 8'h00, 1'b0, 1'b0, 1'b1, 6'd23};
    vecs[10] = '{25'h1FFFFFF, 8'hFD, 24'hFFFFFF, 8'hFE, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[11] = '{25'h0400000, 8'h00, 24'h400000, 8'h00, 1'b0, 1'b0, 1'b1, 6'd0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mant_in   = '0;
    bus.exp_in    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mant", 32'(bus.mant_out), 32'd0);
    checkOutput("rst_exp", 32'(bus.exp_out), 32'd0);
    checkOutput("rst_flags", 32'({bus.zero, bus.overflow, bus.underflow}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      runVector(i);
    end

    // Consumer stalls for five cycles: result and flags must hold, no new accept.
    applyStimulus(vecs[1].mant, vecs[1].ex, shifts, ok);
    if (ok) begin
      held_mant = bus.mant_out;
      held_exp  = bus.exp_out;
      checkOutput("stall_mant_first", 32'(held_mant), 32'h800000);
      checkOutput("stall_exp_first", 32'(held_exp), 32'h69);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        checkOutput($sformatf("stall%0d_ovalid", c), 32'(bus.out_valid), 32'd1);
        checkOutput($sformatf("stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
        checkOutput($sformatf("stall%0d_mant", c), 32'(bus.mant_out), 32'h800000);
        checkOutput($sformatf("stall%0d_exp", c), 32'(bus.exp_out), 32'h69);
      end
      releaseResult("stall");
    end

    // Reset mid-shift discards the item; out_valid must never rise afterwards.
    @(negedge clk);
    bus.mant_in  = 25'h0000001;
    bus.exp_in   = 8'h80;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("midshift_busy", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_mant", 32'(bus.mant_out), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checkOutput("midrst_no_ovalid", 32'(seen), 32'd0);

    runVector(2);
    runVector(5);

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nmiss);
    $finish;
  end

endmodule
